// File: rtl/preview_window.sv
// preview_window: next-piece preview renderer for the VGA path.
// Decides whether the scanned pixel falls inside the preview window. It
// addresses an external synchronous sprite ROM. It then produces a pixel-on
// flag that lines up with the ROM output.
// A new sprite selection takes effect only at frame boundaries, so the
// preview never tears.
module preview_window #(
  parameter int X0          = 100,
  parameter int Y0          = 10,
  parameter int W           = 100,
  parameter int H           = 78,
  parameter int SCALE_LOG2  = 0,
  parameter int NUM_SPRITES = 7,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = 16,
  parameter bit INVERT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       col_addr_sig,
  input  logic [10:0]       row_addr_sig,
  input  logic              frame_start,
  input  logic [2:0]        sprite_sel,
  input  logic              sel_valid,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              pix_on,
  output logic              in_window
);

  // Window bounds are held at 32 bits so that X0 + scaled width can never wrap.
  localparam logic [31:0] X_LO      = 32'(X0);
  localparam logic [31:0] X_HI      = 32'(X0 + (W << SCALE_LOG2));
  localparam logic [31:0] Y_LO      = 32'(Y0);
  localparam logic [31:0] Y_HI      = 32'(Y0 + (H << SCALE_LOG2));
  localparam logic [31:0] SPR_WORDS = 32'(W * H);
  localparam logic [31:0] ROW_WORDS = 32'(W);
  localparam logic [3:0]  NUM_SEL   = 4'(NUM_SPRITES);

  logic [31:0]       col_w;
  logic [31:0]       row_w;
  logic [31:0]       lx;
  logic [31:0]       ly;
  logic              win;
  logic [ADDR_W-1:0] addr_next;
  logic              sel_ok;
  logic [2:0]        pending;
  logic [2:0]        active;

  // Window flag and ROM address of the pixel currently being presented.
  // NOTE: each variable is assigned first, before any other use, so every path drives it and no latch is inferred.
  always_comb begin
    col_w     = 32'(col_addr_sig);
    row_w     = 32'(row_addr_sig);
    win       = (col_w >= X_LO) && (col_w < X_HI) && (row_w >= Y_LO) && (row_w < Y_HI);
    // When the pixel is outside the window these wrap, but win masks them below.
    lx        = (col_w - X_LO) >> SCALE_LOG2;
    ly        = (row_w - Y_LO) >> SCALE_LOG2;
    addr_next = ADDR_W'(32'(active) * SPR_WORDS + ly * ROW_WORDS + lx);
    sel_ok    = sel_valid && ({1'b0, sprite_sel} < NUM_SEL);
  end

  // Sprite selection: the request is held in pending and copied to active at
  // frame start. A request that arrives together with frame_start takes effect at once.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (sel_ok) begin
        pending <= sprite_sel;
      end
      if (frame_start) begin
        active <= sel_ok ? sprite_sel : pending;
      end
    end
  end

  // Stage 1: the ROM address. Window and blank enter a delay line that is
  // ROM_LAT+1 stages deep, so that they line up with rom_data.
  logic [ROM_LAT:0] win_dl;
  logic [ROM_LAT:0] blank_dl;

  // Address register plus window/blank delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      win_dl   <= '0;
      blank_dl <= '0;
    end else begin
      rom_addr <= win ? addr_next : '0;
      win_dl   <= {win_dl[ROM_LAT-1:0], win};
      blank_dl <= {blank_dl[ROM_LAT-1:0], blank};
    end
  end

  // Output stage: combine the ROM pixel with the delayed window and blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on    <= 1'b0;
      in_window <= 1'b0;
    end else begin
      pix_on    <= win_dl[ROM_LAT] & (rom_data ^ INVERT) & ~blank_dl[ROM_LAT];
      in_window <= win_dl[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_preview_window.sv
// Testbench for preview_window. Two instances share one stimulus stream:
// - the default configuration;
// - 2x scaling with a 2-cycle ROM and INVERT=0.
// Expected results come from a behavioural model of the window, address and
// selection rules. A monitor checks them against the DUT from per-instance queues.
module tb_preview_window;

  localparam int X0   = 100;
  localparam int Y0   = 10;
  localparam int W    = 100;
  localparam int H    = 78;
  localparam int NSPR = 7;

  typedef struct packed {
    logic [15:0] addr;
    logic        win;
    logic        pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] col = '0;
  logic [10:0] row = '0;
  logic        frame_start = 1'b0;
  logic [2:0]  sprite_sel = '0;
  logic        sel_valid = 1'b0;
  logic        blank = 1'b0;

  logic [15:0] rom_addr_a, rom_addr_b;
  logic        rom_data_a = 1'b0;
  logic        rom_data_b = 1'b0;
  logic        rom_pipe_b = 1'b0;
  logic        pix_on_a, pix_on_b, in_window_a, in_window_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   model_active  = 0;
  int   model_pending = 0;
  exp_t qa_addr[$], qa_pix[$], qb_addr[$], qb_pix[$];

  always #5 clk = ~clk;

  preview_window u_dut_a (
    .clk(clk), .rst_n(rst_n), .col_addr_sig(col), .row_addr_sig(row),
    .frame_start(frame_start), .sprite_sel(sprite_sel), .sel_valid(sel_valid),
    .blank(blank), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .pix_on(pix_on_a), .in_window(in_window_a)
  );

  preview_window #(.SCALE_LOG2(1), .ROM_LAT(2), .INVERT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .col_addr_sig(col), .row_addr_sig(row),
    .frame_start(frame_start), .sprite_sel(sprite_sel), .sel_valid(sel_valid),
    .blank(blank), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .pix_on(pix_on_b), .in_window(in_window_b)
  );

  // Sprite ROM contents: a fixed pattern of address bits, 0 at address 0.
  function automatic logic rom_bit(input logic [15:0] a);
    return a[0] ^ a[4] ^ a[9];
  endfunction

  // Synchronous ROM models: latency 1 for instance a and latency 2 for instance b.
  always @(posedge clk) begin
    rom_data_a <= rom_bit(rom_addr_a);
    rom_pipe_b <= rom_bit(rom_addr_b);
    rom_data_b <= rom_pipe_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the window test and address computed directly from screen coordinates.
  function automatic exp_t expect_px(input int c, input int r, input bit blk,
                                     input int s, input bit inv, input int act);
    exp_t e;
    int   xe = X0 + (W << s);
    int   ye = Y0 + (H << s);
    e.win  = (c >= X0) && (c < xe) && (r >= Y0) && (r < ye);
    e.addr = e.win ? 16'((act * W * H + ((r - Y0) >> s) * W + ((c - X0) >> s)) % 65536) : 16'd0;
    e.pix  = e.win && (rom_bit(e.addr) ^ inv) && !blk;
    return e;
  endfunction

  // Present one pixel for one cycle and queue its expected responses.
  task automatic drive(input int c, input int r, input bit blk, input bit sv,
                       input int sel, input bit fs);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    col = 11'(c); row = 11'(r); blank = blk;
    sel_valid = sv; sprite_sel = 3'(sel); frame_start = fs;
    ea = expect_px(c, r, blk, 0, 1'b1, model_active);
    eb = expect_px(c, r, blk, 1, 1'b0, model_active);
    qa_addr.push_back(ea); qa_pix.push_back(ea);
    qb_addr.push_back(eb); qb_pix.push_back(eb);
    if (fs) model_active = (sv && sel < NSPR) ? sel : model_pending;
    if (sv && sel < NSPR) model_pending = sel;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic flush();
    qa_addr.delete(); qa_pix.delete(); qb_addr.delete(); qb_pix.delete();
    model_active = 0; model_pending = 0;
  endtask

  // Assert reset between clock edges. The outputs must clear before any edge arrives.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sel_valid = 1'b0; frame_start = 1'b0; blank = 1'b0; col = '0; row = '0;
    #1;
    mon_en = 1'b0;
    check("rst_a_rom_addr",  32'(rom_addr_a),  32'd0);
    check("rst_a_pix_on",    32'(pix_on_a),    32'd0);
    check("rst_a_in_window", 32'(in_window_a), 32'd0);
    check("rst_b_rom_addr",  32'(rom_addr_b),  32'd0);
    check("rst_b_pix_on",    32'(pix_on_b),    32'd0);
    check("rst_b_in_window", 32'(in_window_b), 32'd0);
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor. Every cycle the DUTs present one address and one pixel. Each is
  // compared with the queue entry issued 1 cycle earlier (address) or
  // ROM_LAT+2 cycles earlier (pixel).
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (qa_addr.size() >= 2) begin
        e = qa_addr.pop_front();
        check("a_rom_addr", 32'(rom_addr_a), 32'(e.addr));
      end
      if (qa_pix.size() >= 4) begin
        e = qa_pix.pop_front();
        check("a_pix_on",    32'(pix_on_a),    32'(e.pix));
        check("a_in_window", 32'(in_window_a), 32'(e.win));
      end
      if (qb_addr.size() >= 2) begin
        e = qb_addr.pop_front();
        check("b_rom_addr", 32'(rom_addr_b), 32'(e.addr));
      end
      if (qb_pix.size() >= 5) begin
        e = qb_pix.pop_front();
        check("b_pix_on",    32'(pix_on_b),    32'(e.pix));
        check("b_in_window", 32'(in_window_b), 32'(e.win));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected run to complete");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin : stimulus
    int c, r, sel;
    bit blk, sv, fs;

    #1 rst_n = 1'b0;
    #2;
    check("init_a_rom_addr",  32'(rom_addr_a),  32'd0);
    check("init_a_pix_on",    32'(pix_on_a),    32'd0);
    check("init_a_in_window", 32'(in_window_a), 32'd0);
    check("init_b_rom_addr",  32'(rom_addr_b),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Window corners and edges with sprite 0.
    drive(0, 0, 0, 0, 0, 1);
    drive(100, 10, 0, 0, 0, 0);
    drive(199, 87, 0, 0, 0, 0);
    drive(200, 87, 0, 0, 0, 0);
    drive(99, 10, 0, 0, 0, 0);
    drive(150, 20, 0, 0, 0, 0);
    // Selection is held back until frame_start.
    drive(0, 0, 0, 1, 2, 0);
    drive(150, 20, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(150, 20, 0, 0, 0, 0);
    drive(100, 40, 0, 1, 3, 0);
    drive(120, 40, 0, 0, 0, 0);
    drive(150, 41, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 7, 0);
    drive(150, 20, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(150, 20, 0, 0, 0, 0);
    // A selection arriving together with frame_start takes effect in the same frame.
    drive(0, 0, 0, 1, 5, 1);
    drive(150, 20, 0, 0, 0, 0);
    // Pixel at address 0, first unblanked and then blanked.
    drive(0, 0, 0, 1, 0, 1);
    drive(100, 10, 0, 0, 0, 0);
    drive(100, 10, 1, 0, 0, 0);
    drive(101, 10, 0, 0, 0, 0);
    // Points on the scaled window.
    drive(103, 15, 0, 0, 0, 0);
    drive(299, 165, 0, 0, 0, 0);
    drive(300, 10, 0, 0, 0, 0);
    idle(6);

    // Random pixels, blanking and selection traffic.
    for (int i = 0; i < 3000; i++) begin
      c   = int'($urandom_range(320, 80));
      r   = int'($urandom_range(180, 0));
      blk = ($urandom_range(7, 0) == 0);
      sv  = ($urandom_range(15, 0) == 0);
      sel = int'($urandom_range(7, 0));
      fs  = ($urandom_range(63, 0) == 0);
      if (fs) c = 0;
      drive(c, r, blk, sv, sel, fs);
    end
    idle(6);

    // Scan the whole window on sprite 4.
    drive(0, 0, 0, 1, 4, 1);
    for (int y = Y0; y < Y0 + H; y++)
      for (int x = X0; x < X0 + W; x++)
        drive(x, y, 1'b0, 1'b0, 0, 1'b0);
    idle(6);

    // Scan again and reset in the middle of the window. With no frame_start
    // after the reset, the base falls back to sprite 0.
    drive(0, 0, 0, 0, 0, 1);
    for (int y = Y0; y < Y0 + H; y++)
      for (int x = X0; x < X0 + W; x++) begin
        if (y == 40 && x == 150) async_reset();
        drive(x, y, 1'b0, 1'b0, 0, 1'b0);
      end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preview_window.md
# preview_window

Parametrised next-piece preview renderer for the VGA display path. For each scanned pixel it decides whether the pixel lies inside a configurable preview window, generates the address into an external sprite ROM, and emits a pixel-on flag aligned to the ROM output. It holds several sprites (one per piece type) and takes a new selection only at frame boundaries, so no tearing occurs. Optional integer pixel replication scales the sprite up. It sits between the VGA timing generator (col/row counters) and the colour mux, and drives one synchronous ROM port.

## Interface
- X0, 100: window left edge, screen columns
- Y0, 10: window top edge, screen rows
- W, 100: sprite width in ROM pixels
- H, 78: sprite height in ROM pixels
- SCALE_LOG2, 0: on-screen replication factor 2^SCALE_LOG2 in both axes
- NUM_SPRITES, 7: sprites stored back-to-back in the ROM
- ROM_LAT, 1: ROM read latency in cycles (≥1)
- ADDR_W, 16: ROM address width; must hold NUM_SPRITES*W*H-1
- INVERT, 1: 1 means the ROM stores 0 for "on" pixels
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- col_addr_sig  in  11  current scan column
- row_addr_sig  in  11  current scan row
- frame_start  in  1  one-cycle pulse at start of frame, outside the window
- sprite_sel  in  3  requested sprite index
- sel_valid  in  1  qualifies sprite_sel for one cycle
- blank  in  1  forces pix_on low, e.g. in the game-over screen
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  1  ROM output, valid ROM_LAT cycles after rom_addr
- pix_on  out  1  registered pixel-on flag
- in_window  out  1  registered window flag, aligned with pix_on

## Operation
- Window: col in [X0, X0+(W<<SCALE_LOG2)), row in [Y0, Y0+(H<<SCALE_LOG2)). Bounds are computed at full 11-bit-plus width with no wrap.
- Local coordinates: lx = (col-X0)>>SCALE_LOG2, ly = (row-Y0)>>SCALE_LOG2.
- Address: rom_addr = active*W*H + ly*W + lx. Multiplication is by constants only, and the result is truncated to ADDR_W.
- Outside the window, rom_addr = 0.
- Selection registers are `pending` and `active`.
  - sel_valid with sprite_sel < NUM_SPRITES: pending ← sprite_sel.
  - sel_valid with sprite_sel ≥ NUM_SPRITES: ignored, pending is kept.
  - frame_start: active ← pending. The base address changes only here.
  - sel_valid and frame_start in the same cycle: the new valid sprite_sel goes straight to active and pending.
- Pixel value: pix = rom_data ^ INVERT.
- Output: pix_on = win_d & pix & ~blank_d, where win_d and blank_d are the window flag and blank delayed to match the ROM data.
- in_window = win_d, independent of blank.

## Timing
- Cycle 0: col/row/blank are presented.
- Cycle 1: rom_addr and the internal window flag are registered.
- Cycle 1+ROM_LAT: rom_data is valid.
- Cycle 2+ROM_LAT: pix_on and in_window are registered.
- Total latency from col/row to pix_on is ROM_LAT+2 (3 with defaults). The window/blank delay line is ROM_LAT+1 deep.
- Fully pipelined: one pixel per cycle, no stalls, no handshakes.
- Reset values: rom_addr=0, pix_on=0, in_window=0, pending=0, active=0, all delay stages 0.
- Reset mid-frame: outputs go to 0 immediately (asynchronous). After release, output is correct from the next pixel, with active=0 until the first frame_start.
- A blank change affects pix_on exactly ROM_LAT+2 cycles later.

## Test plan
- Defaults, sprite 0, (col,row)=(100,10) → rom_addr=0 at +1 cycle. (199,87) → 7799. (200,87) and (99,10) → rom_addr=0 and in_window=0 at +3 cycles.
- sel=2 with sel_valid, then frame_start, then (150,20) → rom_addr=15600+1000+50=16650. Before frame_start the same pixel gives 1050.
- sel=3 with sel_valid at row 40 mid-frame → addresses stay on the old sprite until frame_start. sel=7 with sel_valid → ignored, and the next frame still uses sprite 3. sel_valid and frame_start in the same cycle with sel=5 → base 39000 that frame.
- SCALE_LOG2=1: (103,15) → rom_addr 2*100+1=201. (299,165) → 7799. (300,10) → outside, 0.
- ROM model with ROM_LAT=1 returning 0 at addr 0: pix_on=1 at +3 cycles. Model returning 1: pix_on=0. Assert blank at the same cycle as the pixel → pix_on=0 at +3 while in_window=1.
- Scan a full window, then assert rst_n=0 mid-window → pix_on, in_window, rom_addr=0 asynchronously. After release with no frame_start, the base is sprite 0.
